// File: rtl/chan_512_packet_snapphase_capture.sv
// Single-channel phase snapshot: packs two 16-bit phases per 32-bit BRAM word, reports busy/done/count.
// Optional build macro SNAPPHASE_DECIM_EN enables sample decimation by ctrl_in[15:12].
//   state       | meaning
//   S_IDLE      | waiting for a rising start bit
//   S_WAIT_SYNC | armed, capture begins the cycle after sync_in
//   S_CAPTURE   | storing qualifying samples of the selected channel
//   S_DONE      | buffer full, held until start drops
module chan_512_packet_snapphase_capture #(
   parameter int ADDR_W  = 10,
   parameter int PHASE_W = 16,
   parameter int CHAN_W  = 9
) (
   input  logic               user_clk,
   input  logic               user_rst,
   input  logic [31:0]        ctrl_in,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic [CHAN_W-1:0]  chan_in,
   input  logic               data_valid,
   input  logic               sync_in,
   output logic               bram_we,
   output logic [ADDR_W-1:0]  bram_addr,
   output logic [31:0]        bram_din,
   output logic [31:0]        status_out
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_SYNC, S_CAPTURE, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_ONE   = 1;

   state_t             state_q, state_d;
   logic               start_q;
   logic [CHAN_W-1:0]  sel_q, sel_d;
   logic               half_q, half_d;
   logic [PHASE_W-1:0] held_q, held_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        din_q, din_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic [31:0]        status_q, status_d;
   logic               start_edge, entry, qual, keep;

   assign start_edge = ctrl_in[0] & ~start_q;
   assign entry      = (state_q == S_IDLE) & start_edge;
   assign qual       = data_valid & (chan_in == sel_q);

`ifdef SNAPPHASE_DECIM_EN
   logic [3:0] decim_q, decim_d, dcnt_q, dcnt_d;
   logic       unused_ctrl;

   assign unused_ctrl = ^{ctrl_in[31:16], ctrl_in[11]};
   assign keep        = qual & (dcnt_q == 4'd0);

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         decim_q <= '0;
         dcnt_q  <= '0;
      end else begin
         decim_q <= decim_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // dcnt counts qualifying samples modulo D+1; a sample is kept when it reads zero
   always_comb begin
      decim_d = decim_q;
      dcnt_d  = dcnt_q;
      if (entry) begin
         decim_d = ctrl_in[15:12];
         dcnt_d  = '0;
      end else if ((state_q == S_CAPTURE) && ctrl_in[0] && qual) begin
         dcnt_d = (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;
      end
   end
`else
   logic unused_ctrl;

   assign unused_ctrl = ^ctrl_in[31:11];
   assign keep        = qual;
`endif

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (start_edge) state_d = ctrl_in[1] ? S_WAIT_SYNC : S_CAPTURE;
         S_WAIT_SYNC: if (!ctrl_in[0]) state_d = S_IDLE;
                      else if (sync_in) state_d = S_CAPTURE;
         S_CAPTURE:   if (!ctrl_in[0]) state_d = S_IDLE;
                      else if (we_q && (addr_q == LAST_ADDR)) state_d = S_DONE;
         S_DONE:      if (!ctrl_in[0]) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // A registered write always finishes and bumps the address, even across an abort
   always_comb begin
      sel_d   = sel_q;
      half_d  = half_q;
      held_d  = held_q;
      we_d    = 1'b0;
      addr_d  = we_q ? addr_q + ADDR_ONE : addr_q;
      din_d   = din_q;
      count_d = count_q;
      if (entry) begin
         sel_d   = ctrl_in[2 +: CHAN_W];
         half_d  = 1'b0;
         addr_d  = '0;
         count_d = '0;
      end else if ((state_q == S_CAPTURE) && ctrl_in[0] && keep) begin
         if (!half_q) begin
            held_d = phase_in;
            half_d = 1'b1;
         end else begin
            we_d    = 1'b1;
            din_d   = {phase_in, held_q};
            half_d  = 1'b0;
            count_d = count_q + CNT_ONE;
         end
      end
      status_d = {state_d == S_DONE,
                  (state_d == S_WAIT_SYNC) || (state_d == S_CAPTURE),
                  {(29-ADDR_W){1'b0}}, count_d};
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         start_q  <= 1'b0;
         sel_q    <= '0;
         half_q   <= 1'b0;
         held_q   <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         count_q  <= '0;
         status_q <= '0;
      end else begin
         start_q  <= ctrl_in[0];
         sel_q    <= sel_d;
         half_q   <= half_d;
         held_q   <= held_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   assign bram_we    = we_q;
   assign bram_addr  = addr_q;
   assign bram_din   = din_q;
   assign status_out = status_q;

endmodule

// File: tb/tb_chan_512_packet_snapphase_capture.sv
// Directed bench for chan_512_packet_snapphase_capture, built with ADDR_W=4 so a full buffer is 16 words.
module tb_chan_512_packet_snapphase_capture;

   logic        user_clk;
   logic        user_rst;
   logic [31:0] ctrl_in;
   logic [15:0] phase_in;
   logic [8:0]  chan_in;
   logic        data_valid;
   logic        sync_in;
   logic        bram_we;
   logic [3:0]  bram_addr;
   logic [31:0] bram_din;
   logic [31:0] status_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   chan_512_packet_snapphase_capture #(.ADDR_W(4), .PHASE_W(16), .CHAN_W(9)) dut (
      .user_clk   (user_clk),
      .user_rst   (user_rst),
      .ctrl_in    (ctrl_in),
      .phase_in   (phase_in),
      .chan_in    (chan_in),
      .data_valid (data_valid),
      .sync_in    (sync_in),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_din   (bram_din),
      .status_out (status_out)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   typedef struct {
      logic [31:0] ctrl;
      logic        dv;
      logic [8:0]  chan;
      logic [15:0] phase;
      logic        sync;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] din;
      logic [31:0] status;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] c, input logic dv, input logic [8:0] ch,
                        input logic [15:0] ph, input logic s);
      ctrl_in    = c;
      data_valid = dv;
      chan_in    = ch;
      phase_in   = ph;
      sync_in    = s;
   endtask

   initial begin
      logic [31:0] exp_din;
      logic        exp_we;

      // ctrl, dv, chan, phase, sync | we, addr, din, status
      vecs[0]  = '{32'h0000_0000, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 32'h0,          32'h0000_0000};
      vecs[1]  = '{32'h0000_0015, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[2]  = '{32'h0000_0015, 1'b1, 9'd5, 16'h0001, 1'b0, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[3]  = '{32'h0000_0015, 1'b1, 9'd5, 16'h0002, 1'b0, 1'b1, 4'd0, 32'h0002_0001, 32'h4000_0001};
      vecs[4]  = '{32'h0000_0015, 1'b1, 9'd7, 16'h9999, 1'b0, 1'b0, 4'd1, 32'h0,          32'h4000_0001};
      vecs[5]  = '{32'h0000_0015, 1'b1, 9'd5, 16'hFFFF, 1'b0, 1'b0, 4'd1, 32'h0,          32'h4000_0001};
      vecs[6]  = '{32'h0000_0015, 1'b1, 9'd5, 16'h8000, 1'b0, 1'b1, 4'd1, 32'h8000_FFFF, 32'h4000_0002};
      vecs[7]  = '{32'h0000_0015, 1'b0, 9'd5, 16'h0000, 1'b0, 1'b0, 4'd2, 32'h0,          32'h4000_0002};
      vecs[8]  = '{32'h0000_0000, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 4'd2, 32'h0,          32'h0000_0002};
      vecs[9]  = '{32'h0000_0017, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[10] = '{32'h0000_0017, 1'b1, 9'd5, 16'h0011, 1'b0, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[11] = '{32'h0000_0017, 1'b1, 9'd5, 16'h0022, 1'b0, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[12] = '{32'h0000_0017, 1'b1, 9'd5, 16'h0033, 1'b1, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[13] = '{32'h0000_0017, 1'b1, 9'd5, 16'h0044, 1'b0, 1'b0, 4'd0, 32'h0,          32'h4000_0000};
      vecs[14] = '{32'h0000_0017, 1'b1, 9'd5, 16'h0055, 1'b0, 1'b1, 4'd0, 32'h0055_0044, 32'h4000_0001};
      vecs[15] = '{32'h0000_0000, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 4'd1, 32'h0,          32'h0000_0001};

      user_rst = 1'b1;
      drive(32'h0, 1'b0, 9'd0, 16'h0, 1'b0);
      tick();
      tick();
      chk("rst_we", {31'b0, bram_we}, 32'h0);
      chk("rst_addr", {28'b0, bram_addr}, 32'h0);
      chk("rst_din", bram_din, 32'h0);
      chk("rst_status", status_out, 32'h0);
      user_rst = 1'b0;
      tick();

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].ctrl, vecs[i].dv, vecs[i].chan, vecs[i].phase, vecs[i].sync);
         tick();
         chk($sformatf("vec%0d_we", i), {31'b0, bram_we}, {31'b0, vecs[i].we});
         chk($sformatf("vec%0d_addr", i), {28'b0, bram_addr}, {28'b0, vecs[i].addr});
         chk($sformatf("vec%0d_status", i), status_out, vecs[i].status);
         if (vecs[i].we) chk($sformatf("vec%0d_din", i), bram_din, vecs[i].din);
      end

      // Fill the whole 16-word buffer at full rate
      drive(32'h15, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      chk("fill_start_status", status_out, 32'h4000_0000);
      for (int i = 0; i < 32; i++) begin
         drive(32'h15, 1'b1, 9'd5, 16'(i), 1'b0);
         tick();
         chk($sformatf("fill%0d_we", i), {31'b0, bram_we}, {31'b0, 1'(i % 2)});
         if (i % 2 == 1) begin
            chk($sformatf("fill%0d_addr", i), {28'b0, bram_addr}, 32'((i - 1) / 2));
            chk($sformatf("fill%0d_din", i), bram_din, {16'(i), 16'(i - 1)});
            chk($sformatf("fill%0d_status", i), status_out, 32'h4000_0000 | 32'((i + 1) / 2));
         end
      end
      drive(32'h15, 1'b1, 9'd5, 16'd32, 1'b0);
      tick();
      chk("full_status", status_out, 32'h8000_0010);
      chk("full_we", {31'b0, bram_we}, 32'h0);
      chk("full_addr_wrap", {28'b0, bram_addr}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(32'h15, 1'b1, 9'd5, 16'(33 + i), 1'b0);
         tick();
         chk($sformatf("done%0d_we", i), {31'b0, bram_we}, 32'h0);
         chk($sformatf("done%0d_status", i), status_out, 32'h8000_0010);
      end
      drive(32'h0, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      chk("done_exit_status", status_out, 32'h0000_0010);

      // Abort after three words, then restart
      drive(32'h15, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      chk("abort_start_status", status_out, 32'h4000_0000);
      for (int i = 0; i < 6; i++) begin
         drive(32'h15, 1'b1, 9'd5, 16'h0100 + 16'(i), 1'b0);
         tick();
      end
      chk("abort_w3_din", bram_din, 32'h0105_0104);
      chk("abort_w3_addr", {28'b0, bram_addr}, 32'h2);
      drive(32'h15, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      drive(32'h0, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      chk("abort_status", status_out, 32'h0000_0003);
      for (int i = 0; i < 2; i++) begin
         drive(32'h0, 1'b1, 9'd5, 16'h0200 + 16'(i), 1'b0);
         tick();
         chk($sformatf("abort_idle%0d_we", i), {31'b0, bram_we}, 32'h0);
      end
      chk("abort_idle_addr", {28'b0, bram_addr}, 32'h3);
      drive(32'h15, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      chk("restart_status", status_out, 32'h4000_0000);
      chk("restart_addr", {28'b0, bram_addr}, 32'h0);
      drive(32'h15, 1'b1, 9'd5, 16'h0A0A, 1'b0);
      tick();
      drive(32'h15, 1'b1, 9'd5, 16'h0B0B, 1'b0);
      tick();
      chk("restart_we", {31'b0, bram_we}, 32'h1);
      chk("restart_waddr", {28'b0, bram_addr}, 32'h0);
      chk("restart_din", bram_din, 32'h0B0B_0A0A);
      chk("restart_count", status_out, 32'h4000_0001);

      // Decimation word D=3; ignored unless the macro is defined
      drive(32'h0, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      drive(32'h3015, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(32'h3015, 1'b1, 9'd5, 16'(i), 1'b0);
         tick();
`ifdef SNAPPHASE_DECIM_EN
         exp_we  = (i == 4) || (i == 12);
         exp_din = (i == 4) ? 32'h0004_0000 : 32'h000C_0008;
`else
         exp_we  = (i % 2 == 1);
         exp_din = {16'(i), 16'(i - 1)};
`endif
         chk($sformatf("decim%0d_we", i), {31'b0, bram_we}, {31'b0, exp_we});
         if (exp_we) chk($sformatf("decim%0d_din", i), bram_din, exp_din);
      end
`ifdef SNAPPHASE_DECIM_EN
      chk("decim_count", status_out, 32'h4000_0002);
`else
      chk("decim_count", status_out, 32'h4000_0008);
`endif

      // Asynchronous reset in the middle of a capture
      drive(32'h0, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      drive(32'h15, 1'b0, 9'd5, 16'h0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(32'h15, 1'b1, 9'd5, 16'h0300 + 16'(i), 1'b0);
         tick();
      end
      chk("prerst_we", {31'b0, bram_we}, 32'h1);
      chk("prerst_addr", {28'b0, bram_addr}, 32'h1);
      #2 user_rst = 1'b1;
      #1;
      chk("midrst_we", {31'b0, bram_we}, 32'h0);
      chk("midrst_addr", {28'b0, bram_addr}, 32'h0);
      chk("midrst_din", bram_din, 32'h0);
      chk("midrst_status", status_out, 32'h0);
      drive(32'h0, 1'b1, 9'd5, 16'h0400, 1'b0);
      #2 user_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         phase_in = 16'h0400 + 16'(i);
         tick();
         chk($sformatf("postrst%0d_we", i), {31'b0, bram_we}, 32'h0);
         chk($sformatf("postrst%0d_status", i), status_out, 32'h0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
